// File: rtl/vector_line_fifo.sv
// Line-segment queue between the vector core and the line-draw engine.
// Latency: a write accepted at edge N is visible on the head outputs right after edge N (FWFT, no bypass).
// Backpressure: full/almostFull are advisory; a write into a full queue without a same-cycle read is dropped and sets overflow.
//
// Ports:
//   clk, rst_b                 clock and synchronous active-low reset
//   wrReq, d*                  segment write request (edge- or level-qualified per EDGE_WR) and payload
//   flush                      synchronous discard of all contents
//   rdAck, q*, qValid          first-word-fall-through head entry and consumer acknowledge
//   full, empty, almostFull    status derived from count
//   count, framesPending       entries held, held entries tagged end-of-frame
//   overflow                   sticky dropped-write flag, cleared by reset or flush
module vector_line_fifo #(
  parameter int DEPTH     = 16,
  parameter int COORD_W   = 11,
  parameter int COLOR_W   = 3,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int EDGE_WR   = 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       wrReq,
  input  logic [COORD_W-1:0]         dStartX,
  input  logic [COORD_W-1:0]         dStartY,
  input  logic [COORD_W-1:0]         dEndX,
  input  logic [COORD_W-1:0]         dEndY,
  input  logic [COLOR_W-1:0]         dColor,
  input  logic                       dLast,
  input  logic                       flush,
  input  logic                       rdAck,
  output logic [COORD_W-1:0]         qStartX,
  output logic [COORD_W-1:0]         qStartY,
  output logic [COORD_W-1:0]         qEndX,
  output logic [COORD_W-1:0]         qEndY,
  output logic [COLOR_W-1:0]         qColor,
  output logic                       qLast,
  output logic                       qValid,
  output logic                       full,
  output logic                       empty,
  output logic                       almostFull,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     framesPending,
  output logic                       overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 * COORD_W + COLOR_W + 1;

  // Storage is deliberately not reset; head outputs are only meaningful with qValid.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             overflow_q, overflow_d;
  logic             last_wr_req_q, last_wr_req_d;

  logic               wr;
  logic               rd;
  logic               wr_accept;
  logic               rd_fire;
  logic               mem_we;
  logic               head_last;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign wr_entry   = {dStartX, dStartY, dEndX, dEndY, dColor, dLast};
  assign head_entry = mem_q[rd_ptr_q];
  assign head_last  = head_entry[0];

  assign {qStartX, qStartY, qEndX, qEndY, qColor, qLast} = head_entry;

  // Status comes only from count; wr_ptr == rd_ptr cannot tell full from empty.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign almostFull    = (count_q >= CNT_W'(AFULL_LVL));
  assign qValid        = !empty;
  assign count         = count_q;
  assign framesPending = frames_q;
  assign overflow      = overflow_q;

  always_comb begin
    // Edge mode mirrors the legacy behaviour: a held request writes once.
    if (EDGE_WR != 0) begin
      wr = wrReq && !last_wr_req_q;
    end else begin
      wr = wrReq;
    end
    rd = rdAck && !empty;
    // A full queue still accepts a write when the head leaves on the same edge.
    wr_accept = wr && (!full || rd) && !flush;
    rd_fire   = rd && !flush;
    mem_we    = wr_accept && rst_b;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frames_d      = frames_q;
    overflow_d    = overflow_q;
    // Sampled even during flush so a request held across flush does not re-fire.
    last_wr_req_d = wrReq;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      frames_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr && !wr_accept) begin
        overflow_d = 1'b1;
      end

      if (wr_accept && !rd_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (!wr_accept && rd_fire) begin
        count_d = count_q - CNT_W'(1);
      end

      // Arriving and departing frame tags in the same cycle cancel out.
      if ((wr_accept && dLast) && !(rd_fire && head_last)) begin
        frames_d = frames_q + CNT_W'(1);
      end else if (!(wr_accept && dLast) && (rd_fire && head_last)) begin
        frames_d = frames_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frames_q      <= '0;
      overflow_q    <= 1'b0;
      last_wr_req_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frames_q      <= frames_d;
      overflow_q    <= overflow_d;
      last_wr_req_q <= last_wr_req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
